alu_mul_seq: RTL and testbench
==============================

// Module: alu_mul_seq
// PURPOSE
//   Multi-cycle sequencer that computes 32-bit multiplies (RV32M MUL, low word) on the shared integer ALU.
//   Uses radix-2 shift-and-add and issues one ALU add per granted cycle.
//   Sits beside the execute stage. It requests the ALU through a req/gnt pair, and the core stalls on o_busy.
//   The ALU itself is instantiated outside this block.
// PARAMETERS
//   XLEN     32           operand/result width; must equal the ALU width (only 32 supported)
//   CNT_W    $clog2(XLEN) iteration counter width (derived, do not override)
// PORTS
//   i_clk         in   1     clock; all state changes on rising edge
//   i_rst         in   1     synchronous active-high reset
//   i_valid       in   1     request valid (operands presented)
//   o_ready       out  1     request accepted when i_valid && o_ready
//   i_a           in   XLEN  multiplicand
//   i_b           in   XLEN  multiplier
//   o_valid       out  1     result valid
//   i_ready       in   1     consumer accepts result when o_valid && i_ready
//   o_result      out  XLEN  product[XLEN-1:0]
//   o_busy        out  1     high in RUN or DONE (core stall)
//   o_alu_req     out  1     ALU ownership request
//   i_alu_gnt     in   1     ALU granted this cycle
//   o_alu_op      out  3     ALU op select (ADD = 3'b000)
//   o_alu_op2     out  1     ALU sub-op select (0 = add)
//   o_alu_x       out  XLEN  ALU operand x
//   o_alu_y       out  XLEN  ALU operand y
//   i_alu_result  in   XLEN  ALU combinational result
// BEHAVIOUR
//   Reset: state=IDLE; o_ready=1; o_valid=0; o_busy=0; o_alu_req=0; o_result, acc, mcand, mplier, cnt = 0.
//   IDLE: o_ready=1. On i_valid: mcand<=i_a, mplier<=i_b, acc<=0, cnt<=0, go to RUN.
//   RUN: o_ready=0, o_alu_req=1, o_alu_op=000, o_alu_op2=0, o_alu_x=acc, o_alu_y = mplier[0] ? mcand : 0.
//   RUN, grant cycle: acc<=i_alu_result, mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
//     If cnt==XLEN-1, go to DONE.
//   RUN, no-grant cycle: all state holds; o_alu_* stay driven. Progress happens only on i_alu_gnt.
//   DONE: o_valid=1, o_result=acc (registered, stable), o_alu_req=0.
//     On i_ready go to IDLE; o_ready rises the next cycle.
//   Outside RUN, o_alu_op, o_alu_op2, o_alu_x and o_alu_y are all 0.
//   Arithmetic: mod 2^XLEN, so signed and unsigned low words are identical (no funct input).
//     Shifted-out bits are dropped.
//   Latency with continuous grant: accept edge, XLEN RUN cycles, then o_valid on the following cycle.
//   Boundaries:
//     - i_valid while busy is ignored (o_ready=0); no queuing.
//     - o_valid and o_result hold under i_ready=0 indefinitely.
//     - i_rst at any time aborts the operation and returns to the reset state on the next edge.
//       The in-flight result is discarded.
//     - Grant arriving on the final iteration is handled identically to any other iteration.
// CONFIGURATION
//   `ALU_MUL_SEQ_EARLY_EXIT_EN`
//   Defined:
//     - At accept, if i_b==0, go straight to DONE with acc=0, skipping RUN.
//     - In RUN, on a grant where (mplier>>1)==0, go to DONE after updating acc.
//     - Latency = 1 + index of the highest set bit of i_b granted iterations.
//   Undefined: exactly XLEN granted iterations for every operand pair.
//   Results are bit-identical in both builds.
// STRUCTURE
//   Shared package alu_pkg:
//     - ALU op localparams ALU_ADD=3'b000, ALU_SLL=3'b001, ALU_SLT=3'b010, ALU_SLTU=3'b011,
//       ALU_XOR=3'b100, ALU_SR=3'b101, ALU_OR=3'b110, ALU_AND=3'b111.
//     - Sub-op localparams OP2_ADD_SRL=1'b0, OP2_SUB_SRA=1'b1.
//     - typedef enum logic [1:0] {IDLE, RUN, DONE} mul_seq_state_t.
//   Single module, no sub-module. FSM, counter and shift registers are all local.
// TESTING
//   1. Multiply 7 by 6, grant held high: o_result=42.
//      o_valid asserts exactly XLEN+1 cycles after accept. Without EARLY_EXIT, 32 ALU grants are used.
//   2. 0xFFFFFFFF x 0xFFFFFFFF gives 0x00000001. 0xFFFFFFFD x 5 gives 0xFFFFFFF1.
//      0x80000000 x 2 gives 0.
//   3. i_alu_gnt low for RUN cycles 5..14: completion delayed by exactly 10 cycles.
//      Result is unchanged and o_alu_x/o_alu_y are stable while stalled.
//   4. i_ready=0 for 4 cycles in DONE: o_valid and o_result hold, o_ready=0, and a new i_valid is ignored.
//      Op accepted only after handshake.
//   5. i_rst pulsed at RUN cycle 10: next cycle o_ready=1, o_busy=0, o_alu_req=0.
//      A following 3 x 4 returns 12.
//   6. Multiply 12345 by 1: with EARLY_EXIT_EN, DONE after 1 grant. Without it, after 32 grants.
//      i_b=0 with EARLY_EXIT_EN goes straight to DONE, o_result=0, no ALU request. Both builds give o_result=12345.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared integer-ALU definitions: op encodings, sub-op encodings and the
// multiply-sequencer state type.
`timescale 1ns/1ps
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SR   = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  localparam logic OP2_ADD_SRL = 1'b0;
  localparam logic OP2_SUB_SRA = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_seq_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-and-add multiplier (low word) that borrows the shared ALU for
// one add per granted cycle. Optional macro: ALU_MUL_SEQ_EARLY_EXIT_EN.
`timescale 1ns/1ps
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy,
  output logic            o_alu_req,
  input  logic            i_alu_gnt,
  output logic [2:0]      o_alu_op,
  output logic            o_alu_op2,
  output logic [XLEN-1:0] o_alu_x,
  output logic [XLEN-1:0] o_alu_y,
  input  logic [XLEN-1:0] i_alu_result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  mul_seq_state_t  state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_busy    = 1'b0;
    o_alu_req = 1'b0;
    o_alu_op  = 3'b000;
    o_alu_op2 = 1'b0;
    o_alu_x   = '0;
    o_alu_y   = '0;

    unique case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          mcand_d  = i_a;
          mplier_d = i_b;
          acc_d    = '0;
          cnt_d    = '0;
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
          state_d  = (i_b == '0) ? DONE : RUN;
`else
          state_d  = RUN;
`endif
        end
      end

      RUN: begin
        o_busy    = 1'b1;
        o_alu_req = 1'b1;
        o_alu_op  = ALU_ADD;
        o_alu_op2 = OP2_ADD_SRL;
        o_alu_x   = acc_q;
        o_alu_y   = mplier_q[0] ? mcand_q : '0;
        // Without a grant the ALU result is not ours, so nothing advances.
        if (i_alu_gnt) begin
          acc_d    = i_alu_result;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
          end
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
          if ((mplier_q >> 1) == '0) begin
            state_d = DONE;
          end
`endif
        end
      end

      DONE: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        if (i_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_result = acc_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq: a vector table plus hand-written stall,
// back-pressure and mid-operation reset sequences, against a behavioural ALU.
`timescale 1ns/1ps
module tb_alu_mul_seq;

  localparam int XLEN = 32;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_valid;
  logic            o_ready;
  logic [XLEN-1:0] i_a;
  logic [XLEN-1:0] i_b;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic            o_busy;
  logic            o_alu_req;
  logic            i_alu_gnt;
  logic [2:0]      o_alu_op;
  logic            o_alu_op2;
  logic [XLEN-1:0] o_alu_x;
  logic [XLEN-1:0] o_alu_y;
  logic [XLEN-1:0] i_alu_result;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_mul_seq #(.XLEN(XLEN)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_a          (i_a),
    .i_b          (i_b),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_result     (o_result),
    .o_busy       (o_busy),
    .o_alu_req    (o_alu_req),
    .i_alu_gnt    (i_alu_gnt),
    .o_alu_op     (o_alu_op),
    .o_alu_op2    (o_alu_op2),
    .o_alu_x      (o_alu_x),
    .o_alu_y      (o_alu_y),
    .i_alu_result (i_alu_result)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural shared ALU: only ADD gives a sum, anything else is visibly wrong.
  assign i_alu_result = (o_alu_op == 3'b000) ? (o_alu_op2 ? (o_alu_x - o_alu_y) : (o_alu_x + o_alu_y))
                                             : (o_alu_x ^ o_alu_y);

  typedef struct {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
    int              hold;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int exp_grants(input logic [XLEN-1:0] b);
    int g;
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
    g = 0;
    for (int i = 0; i < XLEN; i++) if (b[i]) g = i + 1;
`else
    g = XLEN;
`endif
    return g;
  endfunction

  // Called at a negedge with the DUT idle. Stalls grant on cycles lo..hi
  // counted from the accept cycle (cycle 0). Holds DONE for 'hold' cycles.
  task automatic run_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp, input int lo, input int hi, input int hold);
    int cyc, grants, exp_lat, bad_stable;
    logic [XLEN-1:0] cap_x, cap_y;
    cyc = 0; grants = 0; bad_stable = 0; cap_x = '0; cap_y = '0;
    exp_lat = exp_grants(b) + 1 + ((hi >= lo) ? (hi - lo + 1) : 0);
    i_a = a; i_b = b; i_valid = 1'b1; i_ready = 1'b0;
    check("accept_ready", {31'b0, o_ready}, 32'd1);
    while (!o_valid && cyc < 200) begin
      i_alu_gnt = !(cyc >= lo && cyc <= hi);
      #1;
      if (cyc == lo) begin cap_x = o_alu_x; cap_y = o_alu_y; end
      if (cyc > lo && cyc <= hi && (o_alu_x !== cap_x || o_alu_y !== cap_y)) bad_stable++;
      if (o_alu_req && i_alu_gnt) grants++;
      @(negedge i_clk);
      cyc++;
      i_valid = 1'b0;
    end
    i_alu_gnt = 1'b1;
    check("latency", cyc, exp_lat);
    check("result", o_result, exp);
    check("grants", grants, exp_grants(b));
    if (hi >= lo) check("stall_stable", bad_stable, 0);
    check("done_idle_alu", {o_alu_req, o_ready, o_alu_op, o_alu_op2} | o_alu_x | o_alu_y, 32'd0);
    for (int h = 0; h < hold; h++) begin
      i_valid = 1'b1; i_a = 32'h55; i_b = 32'h3;
      @(negedge i_clk);
      check("hold_valid", {30'b0, o_valid, o_ready}, 32'd2);
      check("hold_result", o_result, exp);
    end
    i_valid = 1'b0; i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    check("post_handshake", {30'b0, o_valid, o_ready}, 32'd1);
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_a = '0; i_b = '0; i_ready = 1'b0; i_alu_gnt = 1'b1;

    tbl[0] = '{32'd7,        32'd6,        32'd42,       0};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0};
    tbl[2] = '{32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 0};
    tbl[3] = '{32'h80000000, 32'd2,        32'd0,        0};
    tbl[4] = '{32'd12345,    32'd1,        32'd12345,    0};
    tbl[5] = '{32'h00001234, 32'd0,        32'd0,        0};
    tbl[6] = '{32'h00010000, 32'h00010000, 32'd0,        0};
    tbl[7] = '{32'h12345678, 32'h10,       32'h23456780, 0};
    tbl[8] = '{32'd1000,     32'd1000,     32'd1000000,  4};
    tbl[9] = '{32'd3,        32'd4,        32'd12,       0};

    repeat (3) @(negedge i_clk);
    check("rst_ctrl", {28'b0, o_ready, o_valid, o_busy, o_alu_req}, 32'h8);
    check("rst_result", o_result, 32'd0);
    check("rst_alu_xy", o_alu_x | o_alu_y, 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].exp, 0, -1, tbl[i].hold);
    end

    // Grant withheld for RUN cycles 5..14; multiplier has its MSB set so all 32 iterations run.
    run_op(32'd6, 32'h80000007, 32'd42, 6, 15, 0);

    // Abort mid-operation with reset, then a clean follow-up.
    i_a = 32'hFFFF; i_b = 32'hFFFF; i_valid = 1'b1; i_alu_gnt = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (10) @(negedge i_clk);
    check("pre_rst_busy", {31'b0, o_busy}, 32'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("abort_ctrl", {28'b0, o_ready, o_valid, o_busy, o_alu_req}, 32'h8);
    check("abort_result", o_result, 32'd0);
    i_rst = 1'b0;
    run_op(32'd3, 32'd4, 32'd12, 0, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
